div_fp_iter: RTL and testbench

- Parametrised iterative IEEE-754 floating-point divider; generalises the fixed fp32 divider to any exponent/fraction width (fp16/fp32/fp64 builds).
- Adds a valid/ready handshake on both sides, full subnormal input/output handling and an early-out path for special operands.
- Sits in the arithmetic-unit FPU datapath.
- One division in flight at a time.

---
 rtl/div_fp_iter.sv | 240 ++++++++++++++++++++++++
 tb/tb_div_fp_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div_fp_iter.sv
// Iterative IEEE-754 divider, parametrised on exponent/fraction width.
// Valid/ready on both sides, subnormal in/out, early-out for special operands.
module div_fp_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [2:0]             rm,
    input  logic [EXP_W+MAN_W:0]   dividend,
    input  logic [EXP_W+MAN_W:0]   divisor,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [EXP_W+MAN_W:0]   quotient,
    output logic                   nv,
    output logic                   dz,
    output logic                   of,
    output logic                   uf,
    output logic                   nx,
    output logic                   busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + $clog2(MAN_W + 1) + 2;
    localparam int CW = $clog2(MAN_W + 3);
    localparam logic signed [EW-1:0] ZERO_S  = '0;
    localparam logic signed [EW-1:0] ONE_S   = 1;
    localparam logic signed [EW-1:0] BIAS_S  = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMAX_S  = (1 << EXP_W) - 1;
    localparam logic signed [EW-1:0] MAXSH_S = MAN_W + 2;
    localparam logic [EXP_W:0]       EMAX_U  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_NORM, S_DIV, S_ROUND, S_DONE} state_e;
    typedef enum logic [2:0] {RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2,
                              RM_RUP = 3'd3, RM_RMM = 3'd4} rm_e;

    state_e                r_state, w_next;
    rm_e                   r_rm;
    logic [W-1:0]          r_a, r_b, r_q;
    logic [4:0]            r_flags;
    logic                  r_valid, r_sign;
    logic [MAN_W:0]        r_ma, r_mb;
    logic signed [EW-1:0]  r_ea, r_eb;
    logic [MAN_W+1:0]      r_rem;
    logic [MAN_W+2:0]      r_quo;
    logic [CW-1:0]         r_cnt;

    function automatic logic round_up(input rm_e m, input logic s, input logic lsb,
                                      input logic g, input logic st);
        case (m)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return s & (g | st);
            RM_RUP:  return ~s & (g | st);
            RM_RMM:  return g;
            default: return g & (st | lsb);
        endcase
    endfunction

    function automatic logic signed [EW-1:0] unb_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? ONE_S - BIAS_S
                         : $signed({{(EW-EXP_W){1'b0}}, e}) - BIAS_S;
    endfunction

    // Operand classification
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frc, w_b_frc;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_sgn;
    assign w_a_exp  = r_a[MAN_W +: EXP_W];
    assign w_b_exp  = r_b[MAN_W +: EXP_W];
    assign w_a_frc  = r_a[MAN_W-1:0];
    assign w_b_frc  = r_b[MAN_W-1:0];
    assign w_a_zero = (w_a_exp == '0) && (w_a_frc == '0);
    assign w_b_zero = (w_b_exp == '0) && (w_b_frc == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_frc == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_frc == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_frc != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_frc != '0);
    assign w_a_snan = w_a_nan && !w_a_frc[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_b_frc[MAN_W-1];
    assign w_sgn    = r_a[W-1] ^ r_b[W-1];

    logic           w_special;
    logic [W-1:0]   w_spec_q;
    logic [4:0]     w_spec_f;
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        w_special = 1'b1;
        w_spec_q  = '0;
        w_spec_f  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_q    = QNAN;
            w_spec_f[4] = w_a_snan | w_b_snan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_q    = QNAN;
            w_spec_f[4] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_q = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_q    = {w_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_f[3] = 1'b1;
        end else if (w_b_inf || w_a_zero) begin
            w_spec_q = {w_sgn, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // Significands as unpacked and after one normalisation step
    logic [MAN_W:0]        w_ua, w_ub, w_na, w_nb;
    logic signed [EW-1:0]  w_nea, w_neb;
    assign w_ua  = {w_a_exp != '0, w_a_frc};
    assign w_ub  = {w_b_exp != '0, w_b_frc};
    assign w_na  = r_ma[MAN_W] ? r_ma : {r_ma[MAN_W-1:0], 1'b0};
    assign w_nb  = r_mb[MAN_W] ? r_mb : {r_mb[MAN_W-1:0], 1'b0};
    assign w_nea = r_ma[MAN_W] ? r_ea : r_ea - ONE_S;
    assign w_neb = r_mb[MAN_W] ? r_eb : r_eb - ONE_S;

    logic [MAN_W+2:0] w_diff;
    logic [MAN_W+1:0] w_rem_keep;
    logic             w_ge;
    assign w_diff     = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge       = ~w_diff[MAN_W+2];
    assign w_rem_keep = w_ge ? w_diff[MAN_W+1:0] : r_rem;

    // Rounding: the exponent and fraction are added as one field so a carry renormalises for free
    logic [MAN_W+2:0]        w_qn;
    logic [MAN_W+1:0]        w_m, w_m_sh, w_mask;
    logic signed [EW-1:0]    w_be, w_sh_raw;
    logic [CW-1:0]           w_sh;
    logic [EXP_W-1:0]        w_ef;
    logic [EXP_W+MAN_W:0]    w_sum;
    logic w_st0, w_st, w_tiny_pre, w_inc, w_ovf, w_ovf_inf, w_nx, w_tiny;
    logic [W-1:0]            w_rnd_q;
    assign w_qn       = r_quo[MAN_W+2] ? r_quo : {r_quo[MAN_W+1:0], 1'b0};
    assign w_be       = r_ea - r_eb - (r_quo[MAN_W+2] ? ZERO_S : ONE_S) + BIAS_S;
    assign w_m        = w_qn[MAN_W+2:1];
    assign w_st0      = w_qn[0] | (r_rem != '0);
    assign w_tiny_pre = (w_be < ONE_S);
    assign w_sh_raw   = ONE_S - w_be;
    assign w_sh       = !w_tiny_pre ? '0 : (w_sh_raw > MAXSH_S) ? CW'(MAN_W + 2) : w_sh_raw[CW-1:0];
    assign w_m_sh     = w_m >> w_sh;
    assign w_mask     = ~({(MAN_W+2){1'b1}} << w_sh);
    assign w_st       = w_st0 | (|(w_m & w_mask));
    assign w_ef       = w_tiny_pre ? '0 : w_be[EXP_W-1:0];
    assign w_inc      = round_up(r_rm, r_sign, w_m_sh[1], w_m_sh[0], w_st);
    assign w_sum      = {1'b0, w_ef, w_m_sh[MAN_W:1]} + {{(EXP_W+MAN_W){1'b0}}, w_inc};
    assign w_ovf      = !w_tiny_pre && ((w_be >= EMAX_S) || (w_sum[MAN_W +: EXP_W+1] >= EMAX_U));
    assign w_ovf_inf  = (r_rm == RM_RNE) || (r_rm == RM_RMM) ||
                        ((r_rm == RM_RDN) && r_sign) || ((r_rm == RM_RUP) && !r_sign);
    assign w_nx       = w_m_sh[0] | w_st | w_ovf;
    // Tiny unless unbounded-exponent rounding at full precision would carry up to the minimum normal
    assign w_tiny     = w_tiny_pre && !((w_be == ZERO_S) && (&w_m[MAN_W:1]) &&
                        round_up(r_rm, r_sign, w_m[1], w_m[0], w_st0));
    assign w_rnd_q    = !w_ovf    ? {r_sign, w_sum[EXP_W+MAN_W-1:0]} :
                        w_ovf_inf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                    {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (valid_in) w_next = S_UNPACK;
            S_UNPACK: w_next = w_special ? S_DONE : (w_ua[MAN_W] && w_ub[MAN_W]) ? S_DIV : S_NORM;
            S_NORM:   if (w_na[MAN_W] && w_nb[MAN_W]) w_next = S_DIV;
            S_DIV:    if (r_cnt == '0) w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE:   if (r_valid && ready_out) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a <= '0; r_b <= '0; r_rm <= RM_RNE; r_sign <= 1'b0;
            r_ma <= '0; r_mb <= '0; r_ea <= '0; r_eb <= '0;
            r_rem <= '0; r_quo <= '0; r_cnt <= '0;
            r_q <= '0; r_flags <= '0; r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (valid_in) begin
                    r_a  <= dividend;
                    r_b  <= divisor;
                    r_rm <= (rm > 3'd4) ? RM_RNE : rm_e'(rm);
                end
                S_UNPACK: begin
                    r_sign <= w_sgn;
                    r_ma   <= w_ua;
                    r_mb   <= w_ub;
                    r_ea   <= unb_exp(w_a_exp);
                    r_eb   <= unb_exp(w_b_exp);
                    r_rem  <= {1'b0, w_ua};
                    r_quo  <= '0;
                    r_cnt  <= CW'(MAN_W + 2);
                    if (w_special) begin
                        r_q     <= w_spec_q;
                        r_flags <= w_spec_f;
                    end
                end
                S_NORM: begin
                    r_ma  <= w_na;
                    r_mb  <= w_nb;
                    r_ea  <= w_nea;
                    r_eb  <= w_neb;
                    r_rem <= {1'b0, w_na};
                end
                S_DIV: begin
                    r_quo <= {r_quo[MAN_W+1:0], w_ge};
                    r_rem <= {w_rem_keep[MAN_W:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    r_q     <= w_rnd_q;
                    r_flags <= {1'b0, 1'b0, w_ovf, w_tiny & w_nx, w_nx};
                end
                S_DONE: begin
                    if (r_valid && ready_out) begin
                        r_valid <= 1'b0;
                        r_flags <= '0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_in  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign valid_out = r_valid;
    assign quotient  = r_q;
    assign {nv, dz, of, uf, nx} = r_flags;
endmodule

// File: tb/tb_div_fp_iter.sv
// Directed bench for div_fp_iter: fp32 and fp64 instances, expected results queued on issue.
module tb_div_fp_iter;
    localparam int TMO = 200;

    typedef struct {
        string       tag;
        logic [63:0] q;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        s_valid_in = 0, s_ready_in, s_valid_out, s_ready_out = 1, s_busy;
    logic [2:0]  s_rm = 0;
    logic [31:0] s_dividend = 0, s_divisor = 0, s_quotient;
    logic        s_nv, s_dz, s_of, s_uf, s_nx;
    logic        d_valid_in = 0, d_ready_in, d_valid_out, d_ready_out = 1, d_busy;
    logic [2:0]  d_rm = 0;
    logic [63:0] d_dividend = 0, d_divisor = 0, d_quotient;
    logic        d_nv, d_dz, d_of, d_uf, d_nx;

    div_fp_iter u_dut32 (
        .clock(clock), .reset(reset), .valid_in(s_valid_in), .ready_in(s_ready_in),
        .rm(s_rm), .dividend(s_dividend), .divisor(s_divisor), .valid_out(s_valid_out),
        .ready_out(s_ready_out), .quotient(s_quotient), .nv(s_nv), .dz(s_dz), .of(s_of),
        .uf(s_uf), .nx(s_nx), .busy(s_busy)
    );

    div_fp_iter #(.EXP_W(11), .MAN_W(52)) u_dut64 (
        .clock(clock), .reset(reset), .valid_in(d_valid_in), .ready_in(d_ready_in),
        .rm(d_rm), .dividend(d_dividend), .divisor(d_divisor), .valid_out(d_valid_out),
        .ready_out(d_ready_out), .quotient(d_quotient), .nv(d_nv), .dz(d_dz), .of(d_of),
        .uf(d_uf), .nx(d_nx), .busy(d_busy)
    );

    function automatic logic [63:0] get_q(input bit is64);
        return is64 ? d_quotient : {32'h0, s_quotient};
    endfunction
    function automatic logic [4:0] get_f(input bit is64);
        return is64 ? {d_nv, d_dz, d_of, d_uf, d_nx} : {s_nv, s_dz, s_of, s_uf, s_nx};
    endfunction
    function automatic logic get_vout(input bit is64);
        return is64 ? d_valid_out : s_valid_out;
    endfunction
    function automatic logic get_rdy(input bit is64);
        return is64 ? d_ready_in : s_ready_in;
    endfunction
    function automatic logic get_busy(input bit is64);
        return is64 ? d_busy : s_busy;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic run_op(input string tag, input bit is64, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] m, input logic [63:0] eq,
                          input logic [4:0] ef, input int elat, input bit hold);
        exp_t e;
        int   lat;
        bit   busy_ok;
        e.tag = tag; e.q = eq; e.f = ef; e.lat = elat;
        sb.push_back(e);
        @(negedge clock);
        if (hold) s_ready_out = 1'b0;
        check({tag, ":ready_in_idle"}, 64'(get_rdy(is64)), 64'd1);
        if (is64) begin
            d_valid_in = 1'b1; d_dividend = a; d_divisor = b; d_rm = m;
        end else begin
            s_valid_in = 1'b1; s_dividend = a[31:0]; s_divisor = b[31:0]; s_rm = m;
        end
        @(posedge clock); #1;
        s_valid_in = 1'b0;
        d_valid_in = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!get_vout(is64) && lat < TMO) begin
            busy_ok &= get_busy(is64);
            @(posedge clock); #1;
            lat++;
        end
        busy_ok &= get_busy(is64);
        e = sb.pop_front();
        check({e.tag, ":latency"}, 64'(lat), 64'(e.lat));
        check({e.tag, ":quotient"}, get_q(is64), e.q);
        check({e.tag, ":flags"}, 64'(get_f(is64)), 64'(e.f));
        check({e.tag, ":busy"}, 64'(busy_ok), 64'd1);
        if (hold) begin
            repeat (10) begin
                @(negedge clock);
                s_valid_in = 1'b1;
                s_dividend = $urandom;
                s_divisor  = $urandom;
                @(posedge clock); #1;
                s_valid_in = 1'b0;
                check({e.tag, ":hold_q"}, 64'(s_quotient), e.q);
                check({e.tag, ":hold_flags"}, 64'({s_nv, s_dz, s_of, s_uf, s_nx}), 64'(e.f));
                check({e.tag, ":hold_ready_in"}, 64'(s_ready_in), 64'd0);
                check({e.tag, ":hold_valid_out"}, 64'(s_valid_out), 64'd1);
            end
            @(negedge clock);
            s_ready_out = 1'b1;
        end
        @(posedge clock); #1;
        check({e.tag, ":retire_valid_out"}, 64'(get_vout(is64)), 64'd0);
        check({e.tag, ":retire_ready_in"}, 64'(get_rdy(is64)), 64'd1);
        check({e.tag, ":retire_flags"}, 64'(get_f(is64)), 64'd0);
    endtask

    initial begin
        #12;
        check("reset:quotient", 64'(s_quotient), 64'd0);
        check("reset:flags", 64'({s_nv, s_dz, s_of, s_uf, s_nx}), 64'd0);
        check("reset:ready_in", 64'(s_ready_in), 64'd1);
        check("reset:valid_out", 64'(s_valid_out), 64'd0);
        check("reset:busy", 64'(s_busy), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // fp32 main function and rounding modes
        run_op("one_half",   0, 64'h3F800000, 64'h40000000, 3'd0, 64'h3F000000, 5'b00000, 29, 0);
        run_op("third_rne",  0, 64'h3F800000, 64'h40400000, 3'd0, 64'h3EAAAAAB, 5'b00001, 29, 0);
        run_op("third_rtz",  0, 64'h3F800000, 64'h40400000, 3'd1, 64'h3EAAAAAA, 5'b00001, 29, 0);
        run_op("third_rup",  0, 64'h3F800000, 64'h40400000, 3'd3, 64'h3EAAAAAB, 5'b00001, 29, 0);
        run_op("nthird_rdn", 0, 64'hBF800000, 64'h40400000, 3'd2, 64'hBEAAAAAB, 5'b00001, 29, 0);
        run_op("nthird_rup", 0, 64'hBF800000, 64'h40400000, 3'd3, 64'hBEAAAAAA, 5'b00001, 29, 0);
        run_op("third_rmm",  0, 64'h3F800000, 64'h40400000, 3'd4, 64'h3EAAAAAB, 5'b00001, 29, 0);
        run_op("third_rm7",  0, 64'h3F800000, 64'h40400000, 3'd7, 64'h3EAAAAAB, 5'b00001, 29, 0);

        // special operands
        run_op("x_div_0",    0, 64'h3F800000, 64'h00000000, 3'd0, 64'h7F800000, 5'b01000, 2, 0);
        run_op("0_div_0",    0, 64'h00000000, 64'h00000000, 3'd0, 64'h7FC00000, 5'b10000, 2, 0);
        run_op("snan",       0, 64'h7F800001, 64'h3F800000, 3'd0, 64'h7FC00000, 5'b10000, 2, 0);
        run_op("qnan",       0, 64'h3F800000, 64'hFFC00123, 3'd0, 64'h7FC00000, 5'b00000, 2, 0);
        run_op("inf_div_x",  0, 64'h7F800000, 64'h40000000, 3'd0, 64'h7F800000, 5'b00000, 2, 0);
        run_op("inf_div_inf",0, 64'h7F800000, 64'hFF800000, 3'd0, 64'h7FC00000, 5'b10000, 2, 0);
        run_op("x_div_ninf", 0, 64'h3F800000, 64'hFF800000, 3'd0, 64'h80000000, 5'b00000, 2, 0);

        // range limits
        run_op("ovf_rne",    0, 64'h7F7FFFFF, 64'h3F000000, 3'd0, 64'h7F800000, 5'b00101, 29, 0);
        run_op("ovf_rtz",    0, 64'h7F7FFFFF, 64'h3F000000, 3'd1, 64'h7F7FFFFF, 5'b00101, 29, 0);
        run_op("sub_exact",  0, 64'h00800000, 64'h40000000, 3'd0, 64'h00400000, 5'b00000, 29, 0);
        run_op("min_sub",    0, 64'h00000001, 64'h3F800000, 3'd0, 64'h00000001, 5'b00000, 52, 0);
        run_op("unf_zero",   0, 64'h00000001, 64'h40000000, 3'd0, 64'h00000000, 5'b00011, 52, 0);
        run_op("unf_rup",    0, 64'h00000001, 64'h40000000, 3'd3, 64'h00000001, 5'b00011, 52, 0);

        // back-pressure: result held for 10 cycles while valid_in pulses are ignored
        run_op("hold",       0, 64'h3F800000, 64'h40400000, 3'd0, 64'h3EAAAAAB, 5'b00001, 29, 1);
        run_op("after_hold", 0, 64'h40400000, 64'h3F800000, 3'd0, 64'h40400000, 5'b00000, 29, 0);

        // reset pulse in the middle of a division
        @(negedge clock);
        s_valid_in = 1'b1; s_dividend = 32'h3F800000; s_divisor = 32'h40400000; s_rm = 3'd0;
        @(posedge clock); #1;
        s_valid_in = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst:valid_out", 64'(s_valid_out), 64'd0);
        check("midrst:ready_in", 64'(s_ready_in), 64'd1);
        check("midrst:busy", 64'(s_busy), 64'd0);
        check("midrst:quotient", 64'(s_quotient), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("post_reset", 0, 64'h3F800000, 64'h40400000, 3'd0, 64'h3EAAAAAB, 5'b00001, 29, 0);

        // fp64 build
        run_op("d_half",  1, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0,
               64'h3FE0000000000000, 5'b00000, 58, 0);
        run_op("d_third", 1, 64'h3FF0000000000000, 64'h4008000000000000, 3'd0,
               64'h3FD5555555555555, 5'b00001, 58, 0);
        run_op("d_x_div_0", 1, 64'h3FF0000000000000, 64'h8000000000000000, 3'd0,
               64'hFFF0000000000000, 5'b01000, 2, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
